// File: rtl/pipelined_shifter_pkg.sv
// Shared types and helpers for the pipelined shift/rotate unit.
//   shift_op_t      : operation codes (5..7 are treated as SLL)
//   bit_reverse     : reverse the low w bits of a 64-bit word
//   stage_of_level  : register stage that computes mux level k
//   first_level     : lowest mux level computed in stage s
//   is_left/is_rot  : op decode helpers
package shifter_pkg;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_t;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[i] = x[w-1-i];
        return r;
    endfunction

    function automatic int stage_of_level(input int k, input int l, input int stages);
        return (k * stages) / l;
    endfunction

    // Smallest k with stage_of_level(k) == s, i.e. ceil(s*L/STAGES).
    function automatic int first_level(input int s, input int l, input int stages);
        return (s * l + stages - 1) / stages;
    endfunction

    // Left ops run through the right-only datapath bit-reversed.
    function automatic logic is_left(input logic [2:0] op);
        return !(op == SRL || op == SRA || op == ROR);
    endfunction

    function automatic logic is_rot(input logic [2:0] op);
        return (op == ROL || op == ROR);
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response bundle of the pipelined shifter.
//   slave  : the shifter side (takes operations, drives results)
//   master : the issuing/consuming side
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    import shifter_pkg::*;
    localparam int AW = $clog2(WIDTH);

    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;     // shift_op_t encoding
    logic [WIDTH-1:0] i_in;
    logic [AW-1:0]    i_amt;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_out;
    logic [TAG_W-1:0] o_tag;

    modport slave (
        input  i_valid, i_op, i_in, i_amt, i_tag, i_ready,
        output o_ready, o_valid, o_out, o_tag
    );

    modport master (
        output i_valid, i_op, i_in, i_amt, i_tag, i_ready,
        input  o_ready, o_valid, o_out, o_tag
    );
endinterface

// File: rtl/pipelined_shifter_stage.sv
// One pipeline stage: mux levels FIRST_LVL..LAST_LVL of the right-shift
// network followed by the stage register and its valid bit.
//   clk_i, rst_ni : clock, synchronous active-low reset (valid bit only)
//   flush_i       : drop the stage content at the next edge
//   en_i          : stage may load (it is empty or its content moves on)
//   *_i           : payload from the previous stage (or the entry logic)
//   *_o           : registered payload and valid
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 5,
    parameter int FIRST_LVL = 0,
    parameter int LAST_LVL  = 0,
    localparam int AW       = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       op_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [2:0]       op_o,
    output logic [AW-1:0]    amt_o,
    output logic             fill_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q;
    logic [AW-1:0]    amt_q;
    logic             fill_q;
    logic [TAG_W-1:0] tag_q;

    // Right shift by n; vacated bits take the wrapped-out bits for rotates,
    // otherwise the fill bit. The index wraps naturally at AW bits.
    function automatic logic [WIDTH-1:0] shr_level(input logic [WIDTH-1:0] d, input int n,
                                                   input logic rot, input logic fill);
        logic [WIDTH-1:0] r;
        logic [AW-1:0]    idx;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = AW'(i + n);
            if ((i + n < WIDTH) || rot) r[i] = d[idx];
            else                        r[i] = fill;
        end
        return r;
    endfunction

    always_comb begin
        data_d = data_i;
        for (int k = FIRST_LVL; k <= LAST_LVL; k++)
            if (amt_i[k]) data_d = shr_level(data_d, 1 << k, is_rot(op_i), fill_i);
    end

    always_comb begin
        valid_d = valid_q;
        if (flush_i)   valid_d = 1'b0;
        else if (en_i) valid_d = valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) valid_q <= 1'b0;
        else         valid_q <= valid_d;
    end

    // Payload loads only with a real operation so a held or idle stage
    // keeps its outputs stable.
    always_ff @(posedge clk_i) begin
        if (en_i && valid_i) begin
            data_q <= data_d;
            op_q   <= op_i;
            amt_q  <= amt_i;
            fill_q <= fill_i;
            tag_q  <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign amt_o   = amt_q;
    assign fill_o  = fill_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit with valid/ready flow control, tag and flush.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset (clears all valid bits)
//   i_flush  : drop every in-flight op and any op offered this cycle
//   bus      : slave side of pipelined_shifter_if (op in, result out)
// Results appear STAGES cycles after acceptance when not stalled.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_flush,
    pipelined_shifter_if.slave bus
);

    localparam int L = $clog2(WIDTH);

    // Index 0 is the entry point, index s+1 is the output of stage s.
    logic [STAGES:0]             vld_p;
    logic [STAGES:0][WIDTH-1:0]  data_p;
    logic [STAGES:0][2:0]        op_p;
    logic [STAGES:0][L-1:0]      amt_p;
    logic [STAGES:0]             fill_p;
    logic [STAGES:0][TAG_W-1:0]  tag_p;
    logic [STAGES-1:0]           en;
    logic                        unused_tail;

    // Entry: left ops are reversed so the network only shifts right;
    // SRA fills with the operand MSB captured here.
    assign vld_p[0]  = bus.i_valid;
    assign data_p[0] = is_left(bus.i_op) ? WIDTH'(bit_reverse(64'(bus.i_in), WIDTH)) : bus.i_in;
    assign op_p[0]   = bus.i_op;
    assign amt_p[0]  = bus.i_amt;
    assign fill_p[0] = (bus.i_op == SRA) ? bus.i_in[WIDTH-1] : 1'b0;
    assign tag_p[0]  = bus.i_tag;

    // Combinational ready chain from the consumer back to the entry: a stage
    // loads when it is empty or its successor loads, so bubbles collapse.
    always_comb begin
        en = '0;
        en[STAGES-1] = !vld_p[STAGES] || bus.i_ready;
        for (int s = STAGES - 2; s >= 0; s--)
            en[s] = !vld_p[s+1] || en[s+1];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FL = first_level(s, L, STAGES);
        localparam int LL = first_level(s + 1, L, STAGES) - 1;

        shifter_stage #(
            .WIDTH(WIDTH), .TAG_W(TAG_W), .FIRST_LVL(FL), .LAST_LVL(LL)
        ) u_stage (
            .clk_i   (i_clk),
            .rst_ni  (i_rst_n),
            .flush_i (i_flush),
            .en_i    (en[s]),
            .valid_i (vld_p[s]),
            .data_i  (data_p[s]),
            .op_i    (op_p[s]),
            .amt_i   (amt_p[s]),
            .fill_i  (fill_p[s]),
            .tag_i   (tag_p[s]),
            .valid_o (vld_p[s+1]),
            .data_o  (data_p[s+1]),
            .op_o    (op_p[s+1]),
            .amt_o   (amt_p[s+1]),
            .fill_o  (fill_p[s+1]),
            .tag_o   (tag_p[s+1])
        );
    end

    // Amount and fill are fully consumed by the last stage.
    assign unused_tail = ^{amt_p[STAGES], fill_p[STAGES]};

    // Exit: undo the entry reversal for left ops.
    assign bus.o_ready = en[0];
    assign bus.o_valid = vld_p[STAGES];
    assign bus.o_tag   = tag_p[STAGES];
    assign bus.o_out   = is_left(op_p[STAGES]) ? WIDTH'(bit_reverse(64'(data_p[STAGES]), WIDTH))
                                               : data_p[STAGES];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and table-driven bench for pipelined_shifter in three shapes:
//   A: WIDTH=32 STAGES=2, B: WIDTH=16 STAGES=4, C: WIDTH=64 STAGES=1.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic clk;
    logic rst_n;
    logic flush_a, flush_b, flush_c;

    int checks   = 0;
    int failures = 0;

    pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) ifa ();
    pipelined_shifter_if #(.WIDTH(16), .TAG_W(5)) ifb ();
    pipelined_shifter_if #(.WIDTH(64), .TAG_W(5)) ifc ();

    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_a), .bus(ifa));
    pipelined_shifter #(.WIDTH(16), .STAGES(4), .TAG_W(5)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_b), .bus(ifb));
    pipelined_shifter #(.WIDTH(64), .STAGES(1), .TAG_W(5)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_c), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Offer one op on A alone and check it surfaces exactly 2 cycles later.
    task automatic issue_a(input string nm, input logic [2:0] op, input logic [31:0] din,
                           input logic [4:0] amt, input logic [4:0] tag, input logic [31:0] exp);
        @(negedge clk);
        ifa.i_valid = 1'b1; ifa.i_op = op; ifa.i_in = din; ifa.i_amt = amt;
        ifa.i_tag = tag; ifa.i_ready = 1'b1;
        #1 chk({nm, "_rdy"}, 64'(ifa.o_ready), 64'd1);
        @(negedge clk);
        ifa.i_valid = 1'b0;
        #1 chk({nm, "_early"}, 64'(ifa.o_valid), 64'd0);
        @(negedge clk);
        #1;
        chk({nm, "_valid"}, 64'(ifa.o_valid), 64'd1);
        chk({nm, "_out"}, 64'(ifa.o_out), 64'(exp));
        chk({nm, "_tag"}, 64'(ifa.o_tag), 64'(tag));
    endtask

    // Reference for B built from plain shifts, independent of the mux network.
    function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] x,
                                          input logic [3:0] a);
        logic [31:0] dbl;
        dbl = {x, x};
        case (op)
            3'd1: return x >> a;
            3'd2: return 16'($signed(x) >>> a);
            3'd3: begin dbl = dbl << a; return dbl[31:16]; end
            3'd4: begin dbl = dbl >> a; return dbl[15:0]; end
            default: return x << a;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] din;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [4:0]  tag;
    } exp_t;

    vec_t vecs[15];
    exp_t q[$];
    exp_t e;
    int   nxt_tag, got, bidx;
    logic stall_prev;
    logic [15:0] prev_out;
    logic [4:0]  prev_tag;
    logic [2:0]  bop;
    logic [3:0]  bamt;
    logic [15:0] bin;

    initial begin
        vecs[0]  = '{3'd2, 32'h8000_0010, 5'd4,  32'hF800_0001};
        vecs[1]  = '{3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003};
        vecs[2]  = '{3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[3]  = '{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[4]  = '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[6]  = '{3'd4, 32'h0000_00FF, 5'd4,  32'hF000_000F};
        vecs[7]  = '{3'd3, 32'h1234_5678, 5'd8,  32'h3456_7812};
        vecs[8]  = '{3'd0, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[9]  = '{3'd4, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[10] = '{3'd2, 32'h8000_0010, 5'd0,  32'h8000_0010};
        vecs[11] = '{3'd5, 32'h0000_000F, 5'd4,  32'h0000_00F0};
        vecs[12] = '{3'd7, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
        vecs[13] = '{3'd1, 32'hF000_0000, 5'd4,  32'h0F00_0000};
        vecs[14] = '{3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000};

        rst_n = 1'b0; flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        ifa.i_valid = 0; ifa.i_op = 0; ifa.i_in = 0; ifa.i_amt = 0; ifa.i_tag = 0; ifa.i_ready = 0;
        ifb.i_valid = 0; ifb.i_op = 0; ifb.i_in = 0; ifb.i_amt = 0; ifb.i_tag = 0; ifb.i_ready = 0;
        ifc.i_valid = 0; ifc.i_op = 0; ifc.i_in = 0; ifc.i_amt = 0; ifc.i_tag = 0; ifc.i_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_a_valid", 64'(ifa.o_valid), 64'd0);
        chk("rst_a_ready", 64'(ifa.o_ready), 64'd1);
        chk("rst_b_valid", 64'(ifb.o_valid), 64'd0);
        chk("rst_b_ready", 64'(ifb.o_ready), 64'd1);
        chk("rst_c_valid", 64'(ifc.o_valid), 64'd0);
        chk("rst_c_ready", 64'(ifc.o_ready), 64'd1);

        // Table-driven vectors on A.
        for (int i = 0; i < 15; i++)
            issue_a($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].amt, 5'(i), vecs[i].exp);

        // Backpressure on A: consumer stalls for 5 cycles while issuing back-to-back.
        nxt_tag = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            ifa.i_ready = (cyc >= 5);
            ifa.i_valid = (nxt_tag < 6);
            ifa.i_op = 3'd0; ifa.i_in = 32'(nxt_tag + 1); ifa.i_amt = 5'd1; ifa.i_tag = 5'(nxt_tag);
            #1;
            if (cyc >= 2 && cyc < 5) begin
                chk("stall_ready", 64'(ifa.o_ready), 64'd0);
                chk("stall_valid", 64'(ifa.o_valid), 64'd1);
                chk("stall_out", 64'(ifa.o_out), 64'd2);
                chk("stall_tag", 64'(ifa.o_tag), 64'd0);
            end
            if (ifa.o_valid && ifa.i_ready) begin
                chk("drain_tag", 64'(ifa.o_tag), 64'(got));
                chk("drain_out", 64'(ifa.o_out), 64'(2 * (got + 1)));
                got++;
            end
            if (ifa.i_valid && ifa.o_ready) nxt_tag++;
        end
        chk("drain_count", 64'(got), 64'd6);
        @(negedge clk);
        ifa.i_valid = 1'b0;

        // Flush on A with two ops in flight and a third offered alongside.
        @(negedge clk);
        ifa.i_ready = 1'b1; ifa.i_valid = 1'b1; ifa.i_op = 3'd0; ifa.i_in = 32'h11;
        ifa.i_amt = 5'd0; ifa.i_tag = 5'd10;
        @(negedge clk);
        ifa.i_tag = 5'd11;
        @(negedge clk);
        ifa.i_tag = 5'd12; flush_a = 1'b1;
        #1;
        chk("flush_ready", 64'(ifa.o_ready), 64'd1);
        chk("flush_pre_tag", 64'(ifa.o_tag), 64'd10);
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            flush_a = 1'b0; ifa.i_valid = 1'b0;
            #1 chk("flush_no_valid", 64'(ifa.o_valid), 64'd0);
        end
        issue_a("after_flush", 3'd1, 32'h0000_00F0, 5'd4, 5'd13, 32'h0000_000F);

        // Synchronous reset mid-stream on A.
        @(negedge clk);
        ifa.i_valid = 1'b1; ifa.i_op = 3'd0; ifa.i_in = 32'h5; ifa.i_amt = 5'd0; ifa.i_tag = 5'd20;
        @(negedge clk);
        ifa.i_tag = 5'd21; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ifa.i_valid = 1'b0; ifa.i_ready = 1'b0;
        #1;
        chk("midrst_valid", 64'(ifa.o_valid), 64'd0);
        chk("midrst_ready", 64'(ifa.o_ready), 64'd1);
        ifa.i_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1 chk("midrst_no_valid", 64'(ifa.o_valid), 64'd0);
        end

        // C: single-stage 64-bit.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ifc.i_valid = 1'b1; ifc.i_ready = 1'b1; ifc.i_tag = 5'(3 + i);
            ifc.i_op = (i == 0) ? 3'd4 : 3'd2;
            ifc.i_in = (i == 0) ? 64'h0000_0000_0000_00FF : 64'h8000_0000_0000_0000;
            ifc.i_amt = (i == 0) ? 6'd8 : 6'd63;
            #1 chk("c_ready", 64'(ifc.o_ready), 64'd1);
            @(negedge clk);
            ifc.i_valid = 1'b0;
            #1;
            chk("c_valid", 64'(ifc.o_valid), 64'd1);
            chk("c_out", ifc.o_out, (i == 0) ? 64'hFF00_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF);
            chk("c_tag", 64'(ifc.o_tag), 64'(3 + i));
        end

        // B: randomised ops with random consumer stalls, first 16 ops directed
        // (every code with amount 0, then every code with amount 15).
        bidx = 0; stall_prev = 1'b0; prev_out = '0; prev_tag = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bop  = (bidx < 16) ? 3'(bidx % 8) : 3'($urandom_range(0, 7));
            bamt = (bidx < 8) ? 4'd0 : ((bidx < 16) ? 4'd15 : 4'($urandom_range(0, 15)));
            bin  = 16'($urandom);
            ifb.i_valid = (cyc < 300) && ($urandom_range(0, 3) != 0);
            ifb.i_op = bop; ifb.i_in = bin; ifb.i_amt = bamt; ifb.i_tag = 5'(bidx);
            ifb.i_ready = (cyc >= 300) || ($urandom_range(0, 2) != 0);
            #1;
            if (stall_prev) begin
                chk("b_hold_out", 64'(ifb.o_out), 64'(prev_out));
                chk("b_hold_tag", 64'(ifb.o_tag), 64'(prev_tag));
            end
            if (ifb.o_valid && ifb.i_ready) begin
                if (q.size() == 0) begin
                    chk("b_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("b_out", 64'(ifb.o_out), 64'(e.out));
                    chk("b_tag", 64'(ifb.o_tag), 64'(e.tag));
                end
            end
            if (ifb.i_valid && ifb.o_ready) begin
                q.push_back('{ref16(bop, bin, bamt), 5'(bidx)});
                bidx++;
            end
            stall_prev = ifb.o_valid && !ifb.i_ready;
            prev_out = ifb.o_out; prev_tag = ifb.o_tag;
        end
        chk("b_drain", 64'(q.size()), 64'd0);
        chk("b_issued_directed", 64'(bidx >= 16), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined shift/rotate unit for the execute stage. Replaces the single-cycle 32-bit variable shifter where timing requires it. Adds rotate modes, configurable width and pipeline depth, a valid/ready handshake with backpressure, a pass-through tag and a flush. Results emerge in issue order, a fixed number of cycles after acceptance when not stalled.

## Interface
- `WIDTH`, default 32: data width; power of two, 8..64.
- `STAGES`, default 2: register stages, 1..$clog2(WIDTH); also the unstalled latency.
- `TAG_W`, default 5: width of the sideband tag (e.g. destination register index).
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_flush`  in  1  discard every in-flight operation.
- `i_valid`  in  1  operation offered.
- `o_ready`  out  1  unit can accept this cycle.
- `i_op`  in  3  `shift_op_t` operation code.
- `i_in`  in  WIDTH  operand.
- `i_amt`  in  $clog2(WIDTH)  shift/rotate amount; always used modulo WIDTH by construction.
- `i_tag`  in  TAG_W  sideband, returned unchanged.
- `o_valid`  out  1  result available.
- `i_ready`  in  1  consumer takes the result this cycle.
- `o_out`  out  WIDTH  result.
- `o_tag`  out  TAG_W  tag of the result.

## Operation
- Operation codes:
  - SLL = 0: logical left.
  - SRL = 1: logical right.
  - SRA = 2: arithmetic right.
  - ROL = 3: rotate left.
  - ROR = 4: rotate right.
  - Codes 5..7 behave as SLL.
- Datapath is right-shift only:
  - Left ops (SLL, ROL) bit-reverse the operand at entry and bit-reverse the result at exit.
  - Fill bit per level: 0 for SLL/SRL, the operand MSB (captured at entry) for SRA, the wrapped-out bits for ROL/ROR.
- Levels: L = $clog2(WIDTH) mux levels; level k shifts by 2^k when amt[k] is set.
- Level k is computed in register stage floor(k*STAGES/L). Each stage registers data, op, the remaining amt, fill bit, tag and a valid bit.
- The output reversal is combinational after the last stage. o_out, o_tag and o_valid come from last-stage registers plus that reversal.
- Flow control:
  - Stage s advances when its successor is empty or advancing.
  - The last stage advances when i_ready is high.
  - o_ready = stage-0 advance condition. This is a combinational ready chain; no skid buffer.
  - Accept when i_valid && o_ready.
- Bubbles collapse: an empty stage fills even while downstream is stalled.
- Flush:
  - When i_flush is high, all stage valid bits clear at the next edge.
  - An input offered in the same cycle is dropped, even if o_ready was high.
  - A result presented with i_ready high in the flush cycle counts as consumed.
- Reset: all valid bits 0. Data and tag registers need no reset. Outputs after reset: o_valid = 0, o_ready = 1, o_out and o_tag undefined but stable.

## Timing
- Latency: an operation accepted at edge n has o_valid high after edge n+STAGES, if not stalled.
- Throughput: one op per cycle when i_ready is held high.
- Stall: while o_valid && !i_ready, o_out and o_tag are held stable. Once all STAGES stages are full, o_ready drops in the same cycle.
- i_ready high with o_valid low has no effect.
- Amount 0: for every op, output equals input.
- Amount WIDTH-1 with SRA: output equals the sign replicated.
- Reset mid-operation: in-flight ops are lost and no o_valid follows. Reset has priority over flush.

## Structure
- `shifter_pkg` holds:
  - `typedef enum logic [2:0] shift_op_t` with the codes above.
  - `function automatic bit_reverse`.
  - The stage-to-level mapping as a constant function, `stage_of_level(k, L, STAGES)`.
- Sub-module `shifter_stage`, parametrised by WIDTH, TAG_W, first level and last level: one combinational level range plus its pipeline register and valid/advance logic. The top instantiates STAGES of them via generate.
- Target size: top about 120 lines, stage about 100 lines, package about 40 lines.

## Test plan
- WIDTH=32, STAGES=2; SRA of 0x8000_0010 by 4 -> 0xF800_0001. ROL of 0x8000_0001 by 1 -> 0x0000_0003. Each appears exactly 2 cycles after acceptance.
- WIDTH=32, i_ready low for 5 cycles while issuing back-to-back. Required: o_ready drops once 2 ops are held, o_out stays stable, and all results then drain in order with tags 0,1,2,…
- Flush with 2 ops in flight and a third offered in the same cycle -> no o_valid on any later cycle; the next op accepted afterwards completes normally.
- WIDTH=16, STAGES=4; randomised ops and amounts against a reference model, with random i_ready. Covers amount 0, amount 15 and codes 5..7 (these must match SLL).
- Assert i_rst_n low for one cycle mid-stream -> o_valid = 0 and o_ready = 1 on the following cycle; the in-flight tags never appear.
- WIDTH=64, STAGES=1; ROR of 0x0000_0000_0000_00FF by 8 -> 0xFF00_0000_0000_0000 with 1-cycle latency.
